// File: rtl/linsens_pkg.sv
// Shared types and parameter checks for the line-sensor sequencer.
package linsens_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      INTEG   = 2'd1,
      READOUT = 2'd2,
      WAIT    = 2'd3
   } seq_state_e;

   // True when the sequencer parameters describe a usable sensor timing.
   function automatic bit params_ok(input int div, input int st_period, input int st_high,
                                    input int num_pix, input int fcnt_w);
      return (div >= 2) && (st_high >= 1) && (st_high < st_period) &&
             (num_pix >= 2) && (fcnt_w >= 1);
   endfunction

endpackage

// File: rtl/linsens_seq_ctrl_sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   // Shift the input through the synchroniser and flag a 0->1 step.
   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
   end

   // Synchroniser, history and edge flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/linsens_seq_ctrl.sv
// Line-sensor sequencer: sensor clock, frame-synchronous ST, TRG pixel
// indexing and EOC frame termination with single-shot/continuous modes.
module linsens_seq_ctrl
   import linsens_pkg::*;
#(
   parameter int DIV       = 8,
   parameter int ST_PERIOD = 1000,
   parameter int ST_HIGH   = 200,
   parameter int NUM_PIX   = 1024,
   parameter int FCNT_W    = 16
) (
   input  logic                       FPGA_CLK,
   input  logic                       FPGA_RST,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       cont_mode,
   input  logic                       TRG,
   input  logic                       EOC,
   output logic                       SENSOR_CLK,
   output logic                       ST,
   output logic                       busy,
   output logic                       pix_valid,
   output logic [$clog2(NUM_PIX)-1:0] pix_idx,
   output logic                       frame_done,
   output logic [FCNT_W-1:0]          frame_cnt,
   output logic                       timeout_err,
   output logic                       pix_err
);

   localparam int DIV_W = $clog2(DIV);
   localparam int STC_W = $clog2(ST_PERIOD);
   localparam int IDX_W = $clog2(NUM_PIX);
   localparam int ACC_W = $clog2(NUM_PIX + 1);
   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
   localparam logic [STC_W-1:0] ST_HIGH_LAST = STC_W'(ST_HIGH - 1);
   localparam logic [STC_W-1:0] ST_PER_LAST  = STC_W'(ST_PERIOD - 1);
   localparam logic [ACC_W-1:0] ACC_FULL     = ACC_W'(NUM_PIX);

   generate
      if (!params_ok(DIV, ST_PERIOD, ST_HIGH, NUM_PIX, FCNT_W)) begin : g_param_err
         $error("linsens_seq_ctrl: parameter out of range");
      end
   endgenerate

   seq_state_e        state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              sclk_q, sclk_d;
   logic [STC_W-1:0]  st_cnt_q, st_cnt_d;
   logic              st_q, st_d;
   logic              busy_q, busy_d;
   logic              stop_req_q, stop_req_d;
   logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
   logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
   logic              pix_valid_q, pix_valid_d;
   logic              frame_done_q, frame_done_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic              timeout_err_q, timeout_err_d;
   logic              pix_err_q, pix_err_d;

   logic              trg_rise, eoc_rise;
   logic              sclk_tick, sclk_fall;
   logic              trg_take, trg_over;
   logic [ACC_W-1:0]  acc_next;
   logic [STC_W-1:0]  st_cnt_inc;

   sync_edge_det u_trg_edge (.clk(FPGA_CLK), .rst_n(FPGA_RST), .din(TRG), .rise(trg_rise));
   sync_edge_det u_eoc_edge (.clk(FPGA_CLK), .rst_n(FPGA_RST), .din(EOC), .rise(eoc_rise));

   assign sclk_tick  = (div_cnt_q == DIV_LAST);
   assign sclk_fall  = sclk_tick & sclk_q;
   assign trg_take   = trg_rise & (acc_cnt_q < ACC_FULL);
   assign trg_over   = trg_rise & ~(acc_cnt_q < ACC_FULL);
   assign acc_next   = trg_take ? (acc_cnt_q + ACC_W'(1)) : acc_cnt_q;
   assign st_cnt_inc = (st_cnt_q == ST_PER_LAST) ? {STC_W{1'b0}} : (st_cnt_q + STC_W'(1));

   // Free-running sensor clock divider, independent of the sequencer state.
   always_comb begin
      if (sclk_tick) begin
         div_cnt_d = {DIV_W{1'b0}};
         sclk_d    = ~sclk_q;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
         sclk_d    = sclk_q;
      end
   end

   // Frame sequencer: ST timing, pixel acceptance, frame termination and flags.
   always_comb begin
      state_d       = state_q;
      st_cnt_d      = st_cnt_q;
      st_d          = st_q;
      busy_d        = busy_q;
      acc_cnt_d     = acc_cnt_q;
      pix_idx_d     = pix_idx_q;
      pix_valid_d   = 1'b0;
      frame_done_d  = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      timeout_err_d = timeout_err_q;
      pix_err_d     = pix_err_q;
      if (busy_q && stop) begin
         stop_req_d = 1'b1;
      end else begin
         stop_req_d = stop_req_q;
      end

      case (state_q)
         IDLE: begin
            st_d = 1'b0;
            // busy while in IDLE means a start was accepted and we are armed
            if (!busy_q) begin
               if (start) begin
                  busy_d        = 1'b1;
                  timeout_err_d = 1'b0;
                  pix_err_d     = 1'b0;
                  pix_idx_d     = {IDX_W{1'b0}};
                  acc_cnt_d     = {ACC_W{1'b0}};
               end else begin
                  busy_d = 1'b0;
               end
            end else if (sclk_fall) begin
               state_d  = INTEG;
               st_cnt_d = {STC_W{1'b0}};
               st_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         INTEG: begin
            if (sclk_fall) begin
               st_cnt_d = st_cnt_inc;
               if (st_cnt_q == ST_HIGH_LAST) begin
                  st_d    = 1'b0;
                  state_d = READOUT;
               end else begin
                  st_d = 1'b1;
               end
            end else begin
               st_d = 1'b1;
            end
         end
         READOUT: begin
            st_d = 1'b0;
            if (sclk_fall) begin
               st_cnt_d = st_cnt_inc;
            end else begin
               st_cnt_d = st_cnt_q;
            end
            // a TRG edge coincident with EOC is counted before the frame check
            acc_cnt_d = acc_next;
            if (trg_take) begin
               pix_valid_d = 1'b1;
               pix_idx_d   = IDX_W'(acc_cnt_q);
            end else begin
               pix_valid_d = 1'b0;
            end
            pix_err_d = pix_err_q | trg_over | (eoc_rise & (acc_next != ACC_FULL));
            if (eoc_rise) begin
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
               state_d      = WAIT;
            end else if (sclk_fall && (st_cnt_q == ST_PER_LAST)) begin
               timeout_err_d = 1'b1;
               busy_d        = 1'b0;
               stop_req_d    = 1'b0;
               state_d       = IDLE;
            end else begin
               state_d = READOUT;
            end
         end
         WAIT: begin
            st_d = 1'b0;
            if (sclk_fall) begin
               st_cnt_d = st_cnt_inc;
               if (st_cnt_q == ST_PER_LAST) begin
                  if (cont_mode && !stop_req_q && !stop) begin
                     state_d   = INTEG;
                     st_cnt_d  = {STC_W{1'b0}};
                     st_d      = 1'b1;
                     pix_idx_d = {IDX_W{1'b0}};
                     acc_cnt_d = {ACC_W{1'b0}};
                  end else begin
                     state_d    = IDLE;
                     busy_d     = 1'b0;
                     stop_req_d = 1'b0;
                  end
               end else begin
                  state_d = WAIT;
               end
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d    = IDLE;
            st_d       = 1'b0;
            busy_d     = 1'b0;
            stop_req_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered-output flops.
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
      if (!FPGA_RST) begin
         state_q       <= IDLE;
         div_cnt_q     <= {DIV_W{1'b0}};
         sclk_q        <= 1'b0;
         st_cnt_q      <= {STC_W{1'b0}};
         st_q          <= 1'b0;
         busy_q        <= 1'b0;
         stop_req_q    <= 1'b0;
         acc_cnt_q     <= {ACC_W{1'b0}};
         pix_idx_q     <= {IDX_W{1'b0}};
         pix_valid_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_cnt_q   <= {FCNT_W{1'b0}};
         timeout_err_q <= 1'b0;
         pix_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         sclk_q        <= sclk_d;
         st_cnt_q      <= st_cnt_d;
         st_q          <= st_d;
         busy_q        <= busy_d;
         stop_req_q    <= stop_req_d;
         acc_cnt_q     <= acc_cnt_d;
         pix_idx_q     <= pix_idx_d;
         pix_valid_q   <= pix_valid_d;
         frame_done_q  <= frame_done_d;
         frame_cnt_q   <= frame_cnt_d;
         timeout_err_q <= timeout_err_d;
         pix_err_q     <= pix_err_d;
      end
   end

   assign SENSOR_CLK  = sclk_q;
   assign ST          = st_q;
   assign busy        = busy_q;
   assign pix_valid   = pix_valid_q;
   assign pix_idx     = pix_idx_q;
   assign frame_done  = frame_done_q;
   assign frame_cnt   = frame_cnt_q;
   assign timeout_err = timeout_err_q;
   assign pix_err     = pix_err_q;

endmodule

// File: tb/tb_linsens_seq_ctrl.sv
// Scoreboard bench for linsens_seq_ctrl with a small sensor timing.
module tb_linsens_seq_ctrl;

   localparam int DIV       = 2;
   localparam int ST_PERIOD = 20;
   localparam int ST_HIGH   = 4;
   localparam int NUM_PIX   = 8;
   localparam int FCNT_W    = 16;
   localparam int IDX_W     = $clog2(NUM_PIX);
   localparam int FRAME_CYC = 2 * DIV * ST_PERIOD;
   localparam int ST_CYC    = 2 * DIV * ST_HIGH;
   localparam int SCLK_CYC  = 2 * DIV;

   localparam int SIG_ST   = 0;
   localparam int SIG_BUSY = 1;
   localparam int SIG_TMO  = 2;
   localparam int SIG_SCLK = 3;

   logic FPGA_CLK  = 1'b0;
   logic FPGA_RST  = 1'b1;
   logic start     = 1'b0;
   logic stop      = 1'b0;
   logic cont_mode = 1'b0;
   logic TRG       = 1'b0;
   logic EOC       = 1'b0;
   logic SENSOR_CLK, ST, busy, pix_valid, frame_done, timeout_err, pix_err;
   logic [IDX_W-1:0]  pix_idx;
   logic [FCNT_W-1:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int exp_fcnt = 0;
   int exp_pix_q[$];
   int exp_fcnt_q[$];

   linsens_seq_ctrl #(
      .DIV(DIV), .ST_PERIOD(ST_PERIOD), .ST_HIGH(ST_HIGH), .NUM_PIX(NUM_PIX), .FCNT_W(FCNT_W)
   ) dut (
      .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST), .start(start), .stop(stop),
      .cont_mode(cont_mode), .TRG(TRG), .EOC(EOC), .SENSOR_CLK(SENSOR_CLK), .ST(ST),
      .busy(busy), .pix_valid(pix_valid), .pix_idx(pix_idx), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .timeout_err(timeout_err), .pix_err(pix_err)
   );

   always #5 FPGA_CLK = ~FPGA_CLK;

   // Cycle stamp used for timing measurements.
   always @(posedge FPGA_CLK) cyc <= cyc + 1;

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Pop the scoreboard whenever the DUT reports a pixel or a finished frame.
   always @(negedge FPGA_CLK) begin
      if (pix_valid) begin
         if (exp_pix_q.size() == 0) check_val("pix_valid_unexpected", pix_valid, 0);
         else check_val("pix_idx", pix_idx, exp_pix_q.pop_front());
      end
      if (frame_done) begin
         if (exp_fcnt_q.size() == 0) check_val("frame_done_unexpected", frame_done, 0);
         else check_val("frame_cnt_at_done", frame_cnt, exp_fcnt_q.pop_front());
      end
   end

   function automatic logic get_sig(input int which);
      case (which)
         SIG_ST:   return ST;
         SIG_BUSY: return busy;
         SIG_TMO:  return timeout_err;
         SIG_SCLK: return SENSOR_CLK;
         default:  return 1'b0;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int which, input logic lvl,
                           input int budget, output int at_cyc);
      for (int i = 0; i < budget; i++) begin
         @(negedge FPGA_CLK);
         if (get_sig(which) === lvl) begin
            at_cyc = cyc;
            return;
         end
      end
      check_val({tag, "_timeout"}, get_sig(which), lvl);
      at_cyc = cyc;
   endtask

   task automatic pulse_start();
      @(negedge FPGA_CLK); start = 1'b1;
      @(negedge FPGA_CLK); start = 1'b0;
   endtask

   task automatic trg_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge FPGA_CLK); TRG = 1'b1;
         if (i < NUM_PIX) exp_pix_q.push_back(i);
         repeat (2) @(negedge FPGA_CLK);
         TRG = 1'b0;
         @(negedge FPGA_CLK);
      end
   endtask

   task automatic eoc_pulse();
      @(negedge FPGA_CLK); EOC = 1'b1;
      exp_fcnt++;
      exp_fcnt_q.push_back(exp_fcnt % (1 << FCNT_W));
      repeat (2) @(negedge FPGA_CLK);
      EOC = 1'b0;
   endtask

   task automatic run_frame(input int n_trg, input logic exp_perr, input logic do_stop,
                            output int rise_cyc);
      int fall_cyc;
      wait_sig("st_rise", SIG_ST, 1'b1, 200, rise_cyc);
      wait_sig("st_fall", SIG_ST, 1'b0, 40, fall_cyc);
      check_val("st_high_len", fall_cyc - rise_cyc, ST_CYC);
      if (do_stop) begin
         stop = 1'b1;
         @(negedge FPGA_CLK);
         stop = 1'b0;
      end
      trg_pulses(n_trg);
      eoc_pulse();
      repeat (6) @(negedge FPGA_CLK);
      check_val("pix_err_after_frame", pix_err, exp_perr);
   endtask

   initial begin
      int r1, r2, r3, t, a, b, seen;
      logic [25:0] outs;

      // 1: reset and idle behaviour
      #1 FPGA_RST = 1'b0;
      #1;
      outs = {SENSOR_CLK, ST, busy, pix_valid, pix_idx, frame_done, frame_cnt, timeout_err, pix_err};
      check_val("reset_outputs", outs, 0);
      repeat (3) @(negedge FPGA_CLK);
      FPGA_RST = 1'b1;
      wait_sig("sclk_hi", SIG_SCLK, 1'b1, 20, a);
      wait_sig("sclk_lo", SIG_SCLK, 1'b0, 20, t);
      wait_sig("sclk_hi2", SIG_SCLK, 1'b1, 20, b);
      check_val("sclk_period", b - a, SCLK_CYC);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge FPGA_CLK);
         if (ST || busy) seen = 1;
      end
      check_val("idle_st_busy", seen, 0);

      // 2: single shot
      pulse_start();
      check_val("busy_after_start", busy, 1);
      run_frame(NUM_PIX, 1'b0, 1'b0, r1);
      wait_sig("busy_drop", SIG_BUSY, 1'b0, 200, t);
      check_val("busy_len", t - r1, FRAME_CYC);
      check_val("frame_cnt_s2", frame_cnt, exp_fcnt);
      check_val("timeout_s2", timeout_err, 0);

      // 3: continuous mode, stop during the third frame
      cont_mode = 1'b1;
      pulse_start();
      run_frame(NUM_PIX, 1'b0, 1'b0, r1);
      run_frame(NUM_PIX, 1'b0, 1'b0, r2);
      run_frame(NUM_PIX, 1'b0, 1'b1, r3);
      check_val("cont_period_12", r2 - r1, FRAME_CYC);
      check_val("cont_period_23", r3 - r2, FRAME_CYC);
      wait_sig("busy_drop_cont", SIG_BUSY, 1'b0, 200, t);
      check_val("busy_len_cont", t - r3, FRAME_CYC);
      check_val("frame_cnt_s3", frame_cnt, exp_fcnt);
      seen = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge FPGA_CLK);
         if (ST) seen = 1;
      end
      check_val("no_4th_st", seen, 0);
      cont_mode = 1'b0;

      // 4: missing EOC gives a timeout
      pulse_start();
      wait_sig("tmo_st_rise", SIG_ST, 1'b1, 200, r1);
      wait_sig("tmo_flag", SIG_TMO, 1'b1, 200, t);
      check_val("timeout_at", t - r1, FRAME_CYC);
      check_val("busy_after_tmo", busy, 0);
      check_val("frame_cnt_tmo", frame_cnt, exp_fcnt);
      repeat (8) @(negedge FPGA_CLK);
      pulse_start();
      check_val("tmo_cleared", timeout_err, 0);
      run_frame(NUM_PIX, 1'b0, 1'b0, r1);
      wait_sig("busy_drop_s4", SIG_BUSY, 1'b0, 200, t);

      // 5: too many, then too few pixels
      pulse_start();
      run_frame(NUM_PIX + 2, 1'b1, 1'b0, r1);
      check_val("pix_idx_sat", pix_idx, NUM_PIX - 1);
      wait_sig("busy_drop_s5a", SIG_BUSY, 1'b0, 200, t);
      pulse_start();
      check_val("pix_err_cleared", pix_err, 0);
      run_frame(5, 1'b1, 1'b0, r1);
      wait_sig("busy_drop_s5b", SIG_BUSY, 1'b0, 200, t);
      check_val("frame_cnt_s5", frame_cnt, exp_fcnt);

      // 6: asynchronous reset in READOUT, then a clean frame
      pulse_start();
      wait_sig("rst_st_rise", SIG_ST, 1'b1, 200, r1);
      wait_sig("rst_st_fall", SIG_ST, 1'b0, 40, t);
      trg_pulses(3);
      repeat (6) @(negedge FPGA_CLK);
      #2 FPGA_RST = 1'b0;
      #1;
      outs = {SENSOR_CLK, ST, busy, pix_valid, pix_idx, frame_done, frame_cnt, timeout_err, pix_err};
      check_val("midframe_reset_outputs", outs, 0);
      exp_fcnt = 0;
      exp_pix_q.delete();
      exp_fcnt_q.delete();
      repeat (3) @(negedge FPGA_CLK);
      FPGA_RST = 1'b1;
      pulse_start();
      run_frame(NUM_PIX, 1'b0, 1'b0, r1);
      wait_sig("busy_drop_s6", SIG_BUSY, 1'b0, 200, t);
      check_val("busy_len_s6", t - r1, FRAME_CYC);
      check_val("frame_cnt_s6", frame_cnt, 1);

      check_val("pix_pending", exp_pix_q.size(), 0);
      check_val("done_pending", exp_fcnt_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
